nv_ram_rws_param: RTL and testbench
===================================

NV_RAM_RWS_PARAM -- requirements
Module: nv_ram_rws_param

Interface
- REQ-001: Parameter DW, default 512, data width in bits.
- REQ-002: Parameter AW, default 5, address width in bits.
- REQ-003: Parameter DEPTH, default 32, number of entries; SHALL satisfy DEPTH <= 2**AW.
- REQ-004: Parameter MW, default 64, number of write-mask lanes; DW SHALL be an integer multiple of MW, and lane width is DW/MW.
- REQ-005: Ports:
  - nvdla_core_clk  in  1  sole clock; one clock.
  - nvdla_core_rstn  in  1  reset; asynchronous, active-low.
  - ra  in  AW  read address.
  - re  in  1  read enable.
  - dout  out  DW  read data.
  - dout_vld  out  1  dout carries data for an accepted read.
  - wa  in  AW  write address.
  - we  in  1  write enable.
  - wmsk  in  MW  per-lane write mask.
  - di  in  DW  write data.
  - clr_req  in  1  request a full-array zero fill.
  - clr_busy  out  1  zero-fill sweep in progress.
  - pwrbus_ram_pd  in  32  power-down bus; SHALL have no functional effect.

Function
- REQ-006: Storage SHALL be a DEPTH x DW array with no reset of its contents.
- REQ-007: Write, when we=1 and clr_busy=0 at a clock edge: lane i of M[wa] SHALL take lane i of di for each wmsk[i]=1; other lanes are unchanged.
- REQ-008: A write with wmsk all zero SHALL leave the array unchanged.
- REQ-009: A write with wa >= DEPTH SHALL be discarded.
- REQ-010: Read, when re=1 and clr_busy=0 at a clock edge: ra SHALL be captured into ra_d; dout_vld SHALL be 1 in the next cycle.
- REQ-011: With re=0, ra_d SHALL hold; dout_vld SHALL be 0 in the next cycle.
- REQ-012: Base read latency is 1 cycle. dout SHALL equal the current M[ra_d], so a location written after capture is reflected on dout in the cycle after the write.
- REQ-013: ra_d >= DEPTH SHALL drive dout to all zeros.
- REQ-014: Read and write to the same address at the same edge: the cycle-1 dout SHALL show the newly written lanes (write-through).
- REQ-015: The clear FSM SHALL have two states, IDLE and CLEAR, and an AW-bit entry counter clr_cnt.
- REQ-016: IDLE -> CLEAR when clr_req=1; clr_cnt SHALL be set to 0.
- REQ-017: In CLEAR, each cycle SHALL write all-zeros (all lanes) to M[clr_cnt] and increment clr_cnt.
- REQ-018: CLEAR -> IDLE after the write to entry DEPTH-1, so a sweep lasts exactly DEPTH cycles.
- REQ-019: clr_busy SHALL be 1 exactly when the FSM is in CLEAR.
- REQ-020: In CLEAR, external we and re SHALL be ignored; dout_vld SHALL be 0 in the cycle following any CLEAR cycle.
- REQ-021: clr_req asserted while in CLEAR SHALL be ignored; the sweep SHALL NOT restart.

Reset
- REQ-022: On nvdla_core_rstn=0, asynchronously: FSM=CLEAR, clr_cnt=0, clr_busy=1, dout_vld=0, ra_d=0.
- REQ-023: After reset release, the FSM SHALL auto-sweep all DEPTH entries before accepting any access.
- REQ-024: Reset asserted mid-sweep SHALL restart the sweep from entry 0.
- REQ-025: Array contents SHALL NOT be altered by reset itself.

Configuration
- REQ-026: Macro NV_RAM_DOUT_PIPE_EN defined: dout SHALL be registered from the array read, giving read latency 2.
  - dout_vld SHALL be delayed to match.
  - Registered dout SHALL reset to 0 and SHALL update only when the delayed valid is 1.
  - Write-through per REQ-014 SHALL appear at cycle 2.
- REQ-027: NV_RAM_DOUT_PIPE_EN undefined: behaviour SHALL be exactly REQ-010..REQ-014 with latency 1.

Verification
- REQ-028: Reset release, DEPTH=32 -> clr_busy=1 for exactly 32 cycles; every address then reads 0 with dout_vld=1 one cycle after re.
- REQ-029: Write wa=3, di=all-ones, wmsk=0x1; then read ra=3 -> dout lane 0 all-ones, lanes 1..63 zero (DW=512, MW=64).
- REQ-030: Same-edge we=1, wa=5 and re=1, ra=5 -> next-cycle dout equals new di (cycle 2 when NV_RAM_DOUT_PIPE_EN is defined).
- REQ-031: clr_req pulse, then we=1 and re=1 during CLEAR -> no array change from the write, dout_vld stays 0, and the sweep completes in 32 cycles.
- REQ-032: nvdla_core_rstn pulsed at clr_cnt=17 -> clr_cnt=0 and clr_busy=1 immediately; a full 32-cycle sweep follows.
- REQ-033: DEPTH=24, AW=5, write wa=30 then read ra=30 -> dout=0 and no entry 0..23 modified.

Source files
------------

// File: rtl/nv_ram_rws_param.sv
// nv_ram_rws_param: DEPTH x DW single-clock RAM with one read port and one
// write port. Writes are per-lane masked. A two-state clear FSM zero-fills the
// array after reset and again on each clr_req. While that sweep is running,
// external reads and writes are blocked.
// Optional feature: define NV_RAM_DOUT_PIPE_EN to register dout. This raises
// the read latency from 1 to 2.
module nv_ram_rws_param #(
    parameter int DW    = 512,
    parameter int AW    = 5,
    parameter int DEPTH = 32,
    parameter int MW    = 64
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic [AW-1:0] ra,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [MW-1:0] wmsk,
    input  logic [DW-1:0] di,
    input  logic          clr_req,
    output logic          clr_busy,
    input  logic [31:0]   pwrbus_ram_pd
);

    localparam int            LW       = DW / MW;
    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] w_clr_cnt_nxt;
    logic [AW-1:0] r_ra_d;
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] w_rd_data;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          r_rd_vld;

    // The power-down bus has no functional effect. It is folded into one bit
    // so that it is consumed.
    logic w_unused_pwrbus;
    assign w_unused_pwrbus = ^pwrbus_ram_pd;

    assign clr_busy = (r_state == ST_CLEAR);

    // An external write is dropped during a sweep and when wa is beyond DEPTH.
    // An external read is dropped during a sweep.
    assign w_wr_en = we && !clr_busy && ({1'b0, wa} < LP_DEPTH);
    assign w_rd_en = re && !clr_busy;

    // Clear FSM next-state logic. The sweep visits entries 0..DEPTH-1, then
    // returns to IDLE. A clr_req that arrives during CLEAR has no effect.
    // NOTE: every output of this always_comb gets a default before the case
    // statement, so that no path leaves a signal unassigned and infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                if (r_clr_cnt == LP_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // Clear FSM state register. Reset enters CLEAR at entry 0, so a sweep
    // always follows reset release.
    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // the ordering of evaluation between flops from affecting the result.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Array write port. The sweep writes zeros to every lane. Otherwise, a
    // masked external write updates only the enabled lanes.
    // NOTE: the storage array has no reset. Its contents are initialised by
    // the clear sweep, not by the reset network.
    always_ff @(posedge nvdla_core_clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < MW; i++) begin
                if (wmsk[i]) begin
                    r_mem[wa][i*LW +: LW] <= di[i*LW +: LW];
                end
            end
        end
    end

    // Read address capture and first-stage valid. ra_d keeps its value when
    // no read is accepted.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_ra_d   <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_en;
            if (w_rd_en) begin
                r_ra_d <= ra;
            end
        end
    end

    // Live array read at the captured address. A later write to that entry
    // shows up on the next cycle, and an out-of-range address reads as zero.
    always_comb begin
        w_rd_data = '0;
        if ({1'b0, r_ra_d} < LP_DEPTH) begin
            w_rd_data = r_mem[r_ra_d];
        end
    end

`ifdef NV_RAM_DOUT_PIPE_EN
    logic [DW-1:0] r_dout;
    logic          r_dout_vld;

    // Output register stage. It loads the array read only when that read
    // belongs to an accepted access. Read latency becomes 2.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= r_rd_vld;
            if (r_rd_vld) begin
                r_dout <= w_rd_data;
            end
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
`else
    assign dout     = w_rd_data;
    assign dout_vld = r_rd_vld;
`endif

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Directed testbench for nv_ram_rws_param. u_dut uses the default geometry
// (32 x 512, 64 lanes). u_dut24 uses DEPTH=24 with AW=5 to cover writes and
// reads beyond DEPTH.
module tb_nv_ram_rws_param;

`ifdef NV_RAM_DOUT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic [4:0]   ra, wa;
    logic         re, we, clr_req;
    logic [63:0]  wmsk;
    logic [511:0] di, dout;
    logic         dout_vld, clr_busy;

    logic [4:0]   b_ra, b_wa;
    logic         b_re, b_we;
    logic [3:0]   b_wmsk;
    logic [15:0]  b_di, b_dout;
    logic         b_dout_vld, b_clr_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nv_ram_rws_param u_dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .ra             (ra),
        .re             (re),
        .dout           (dout),
        .dout_vld       (dout_vld),
        .wa             (wa),
        .we             (we),
        .wmsk           (wmsk),
        .di             (di),
        .clr_req        (clr_req),
        .clr_busy       (clr_busy),
        .pwrbus_ram_pd  (32'h0)
    );

    nv_ram_rws_param #(.DW(16), .AW(5), .DEPTH(24), .MW(4)) u_dut24 (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .ra             (b_ra),
        .re             (b_re),
        .dout           (b_dout),
        .dout_vld       (b_dout_vld),
        .wa             (b_wa),
        .we             (b_we),
        .wmsk           (b_wmsk),
        .di             (b_di),
        .clr_req        (1'b0),
        .clr_busy       (b_clr_busy),
        .pwrbus_ram_pd  (32'hFFFF_FFFF)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] m, input logic [511:0] d);
        wa = a; wmsk = m; di = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [511:0] d, output logic v);
        ra = a; re = 1'b1;
        step();
        re = 1'b0;
        repeat (LAT - 1) step();
        d = dout;
        v = dout_vld;
    endtask

    task automatic b_wr(input logic [4:0] a, input logic [15:0] d);
        b_wa = a; b_wmsk = 4'hF; b_di = d; b_we = 1'b1;
        step();
        b_we = 1'b0;
    endtask

    task automatic b_rd(input logic [4:0] a, output logic [15:0] d, output logic v);
        b_ra = a; b_re = 1'b1;
        step();
        b_re = 1'b0;
        repeat (LAT - 1) step();
        d = b_dout;
        v = b_dout_vld;
    endtask

    // Counts clock edges while clr_busy stays high. The count is bounded.
    // When hold_req is set, clr_req and a blocked read/write are driven
    // through the first part of the sweep.
    task automatic sweep_len(input string tag, input bit hold_req, output int n);
        n = 0;
        while (clr_busy && n < 100) begin
            step();
            n++;
            if (hold_req) begin
                check({tag, "_vld"}, {511'd0, dout_vld}, 512'd0);
                if (n == 20) clr_req = 1'b0;
            end
        end
        we = 1'b0; re = 1'b0; clr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d, pat, q;
        logic [15:0]  bd;
        logic         v;
        int           n;

        rstn = 1'b0; ra = '0; wa = '0; re = 1'b0; we = 1'b0; clr_req = 1'b0;
        wmsk = '0; di = '0;
        b_ra = '0; b_wa = '0; b_re = 1'b0; b_we = 1'b0; b_wmsk = '0; b_di = '0;

        // In reset: the DUT is sweeping and nothing is valid.
        #13;
        check("rst_busy", {511'd0, clr_busy}, 512'd1);
        check("rst_vld", {511'd0, dout_vld}, 512'd0);
        check("rst_cnt", {507'd0, u_dut.r_clr_cnt}, 512'd0);
        step();
        rstn = 1'b1;

        // After release, the auto-sweep takes exactly 32 cycles.
        sweep_len("init", 1'b0, n);
        check("init_sweep_len", 512'(n), 512'd32);

        // After the sweep, every entry reads zero with valid set.
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), d, v);
            check("init_vld", {511'd0, v}, 512'd1);
            check("init_zero", d, 512'd0);
        end
        step();
        check("idle_vld_low", {511'd0, dout_vld}, 512'd0);

        // Masked lane write: only lane 0 is written.
        wr(5'd3, 64'h1, '1);
        rd(5'd3, d, v);
        check("lane0_wr", d, 512'hFF);
        // An all-zero mask changes nothing.
        wr(5'd3, 64'h0, {64{8'h5A}});
        rd(5'd3, d, v);
        check("mask_zero", d, 512'hFF);
        // Lane 2 is merged, and the other lanes keep their values.
        wr(5'd3, 64'h4, {64{8'hA5}});
        rd(5'd3, d, v);
        check("lane2_merge", d, 512'hA500FF);
        rd(5'd4, d, v);
        check("neighbor_untouched", d, 512'd0);

        // Write and read of the same address at the same edge: write-through.
        pat = {16{32'hDEADBEEF}};
        wa = 5'd5; wmsk = '1; di = pat; we = 1'b1;
        ra = 5'd5; re = 1'b1;
        step();
        we = 1'b0; re = 1'b0;
        repeat (LAT - 1) step();
        check("wt_vld", {511'd0, dout_vld}, 512'd1);
        check("wt_data", dout, pat);

`ifndef NV_RAM_DOUT_PIPE_EN
        // A write made after the address was captured shows up the next cycle.
        rd(5'd6, d, v);
        check("live_pre", d, 512'd0);
        q = {8{64'h0123_4567_89AB_CDEF}};
        wr(5'd6, '1, q);
        check("live_post", dout, q);
        check("live_vld_low", {511'd0, dout_vld}, 512'd0);
`endif

        // clr_req sweep. Writes and reads during CLEAR are ignored, and the
        // clr_req held high inside CLEAR does not restart the sweep.
        clr_req = 1'b1;
        step();
        check("clr_enter", {511'd0, clr_busy}, 512'd1);
        wa = 5'd0; wmsk = '1; di = '1; we = 1'b1;
        ra = 5'd5; re = 1'b1;
        sweep_len("clr", 1'b1, n);
        check("clr_sweep_len", 512'(n), 512'd32);
        rd(5'd0, d, v);
        check("clr_wr_ignored", d, 512'd0);
        rd(5'd5, d, v);
        check("clr_zeroed", d, 512'd0);
        rd(5'd3, d, v);
        check("clr_zeroed3", d, 512'd0);

        // Reset pulse at clr_cnt=17 restarts the sweep from entry 0.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (17) step();
        check("mid_cnt17", {507'd0, u_dut.r_clr_cnt}, 512'd17);
        rstn = 1'b0;
        #1;
        check("mid_rst_cnt", {507'd0, u_dut.r_clr_cnt}, 512'd0);
        check("mid_rst_busy", {511'd0, clr_busy}, 512'd1);
        check("mid_rst_vld", {511'd0, dout_vld}, 512'd0);
        #1;
        rstn = 1'b1;
        sweep_len("mid", 1'b0, n);
        check("mid_sweep_len", 512'(n), 512'd32);

        // DEPTH=24 instance: an out-of-range write is dropped, and an
        // out-of-range read returns zero.
        check("d24_idle", {511'd0, b_clr_busy}, 512'd0);
        b_wr(5'd23, 16'h1234);
        b_wr(5'd30, 16'hFFFF);
        b_rd(5'd30, bd, v);
        check("d24_oor_vld", {511'd0, v}, 512'd1);
        check("d24_oor_data", {496'd0, bd}, 512'd0);
        b_rd(5'd23, bd, v);
        check("d24_last", {496'd0, bd}, 512'h1234);
        for (int a = 0; a < 23; a++) begin
            b_rd(5'(a), bd, v);
            check("d24_untouched", {496'd0, bd}, 512'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
